// File: rtl/noc_local_interface.sv
// noc_local_interface: PE-side endpoint of a router local port.
// Packetises core requests into 17-bit flits and buffers ejected flits with credit return.
module noc_local_interface #(
   parameter logic [5:0] NODE_ID  = 6'd7,
   parameter int         RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_valid_i,
   input  logic [5:0]  tx_dest_i,
   input  logic [3:0]  tx_len_i,
   output logic        tx_ready_o,
   input  logic [13:0] tx_word_i,
   input  logic        tx_word_valid_i,
   output logic        tx_word_ready_o,
   input  logic        local_full_i,
   output logic [16:0] inj_data_o,
   input  logic [16:0] ej_data_i,
   output logic        consume_o,
   output logic [15:0] rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic        rx_overflow_o
);
   localparam int AW = $clog2(RX_DEPTH);
   localparam int CW = $clog2(RX_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t        state_q, state_d;
   logic [5:0]    dest_q, dest_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [16:0]   inj_q, inj_d;
   logic          take;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = tx_valid_i ? HEAD : IDLE;
         HEAD:    state_d = local_full_i ? HEAD : (cnt_q == 4'd0 ? IDLE : BODY);
         BODY:    state_d = (take && cnt_q == 4'd1) ? IDLE : BODY;
         default: state_d = IDLE;
      endcase
   end

   // Flits are only loaded when the router's look-ahead full flag is low this cycle.
   always_comb begin
      tx_ready_o      = state_q == IDLE;
      take            = state_q == BODY && tx_word_valid_i && !local_full_i;
      tx_word_ready_o = take;
      dest_d          = dest_q;
      cnt_d           = cnt_q;
      inj_d           = '0;
      if (state_q == IDLE && tx_valid_i) begin
         dest_d = tx_dest_i;
         cnt_d  = tx_len_i;
      end
      if (state_q == HEAD && !local_full_i)
         inj_d = {1'b1, cnt_q == 4'd0 ? 2'b11 : 2'b01, dest_q, NODE_ID, 2'b00};
      if (take) begin
         inj_d = {1'b1, cnt_q == 4'd1 ? 2'b10 : 2'b00, tx_word_i};
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         dest_q <= '0;
         cnt_q  <= '0;
         inj_q  <= '0;
      end else begin
         dest_q <= dest_d;
         cnt_q  <= cnt_d;
         inj_q  <= inj_d;
      end

   assign inj_data_o = inj_q;

   logic [15:0]   mem_q [RX_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] occ_q;
   logic          ovf_q, cons_q, push, pop, full, wr;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(RX_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign push          = ej_data_i[16];
   assign full          = occ_q == CW'(RX_DEPTH);
   assign rx_valid_o    = occ_q != '0;
   assign pop           = rx_valid_o && rx_ready_i;
   assign wr            = push && (!full || pop);
   assign rx_data_o     = rx_valid_o ? mem_q[rp_q] : '0;
   assign rx_overflow_o = ovf_q;
   assign consume_o     = cons_q;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp_q   <= '0;
         rp_q   <= '0;
         occ_q  <= '0;
         ovf_q  <= 1'b0;
         cons_q <= 1'b0;
      end else begin
         if (wr) wp_q <= nxt(wp_q);
         if (pop) rp_q <= nxt(rp_q);
         occ_q  <= occ_q + CW'(wr) - CW'(pop);
         if (push && full && !pop) ovf_q <= 1'b1;
         cons_q <= pop;
      end

   always_ff @(posedge clk)
      if (wr) mem_q[wp_q] <= ej_data_i[15:0];
endmodule

// File: tb/tb_noc_local_interface.sv
// tb_noc_local_interface: randomized scoreboard bench for noc_local_interface.
// Packet-level and FIFO-level reference models feed queues checked by free-running monitors.
module tb_noc_local_interface;
   localparam logic [5:0] NID = 6'd7;
   localparam int         RXD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_valid_i, tx_word_valid_i, local_full_i, rx_ready_i;
   logic [5:0]  tx_dest_i;
   logic [3:0]  tx_len_i;
   logic [13:0] tx_word_i;
   logic [16:0] ej_data_i;
   logic        tx_ready_o, tx_word_ready_o, consume_o, rx_valid_o, rx_overflow_o;
   logic [16:0] inj_data_o;
   logic [15:0] rx_data_o;

   noc_local_interface #(.NODE_ID(NID), .RX_DEPTH(RXD)) dut (
      .clk(clk), .rst(rst),
      .tx_valid_i(tx_valid_i), .tx_dest_i(tx_dest_i), .tx_len_i(tx_len_i), .tx_ready_o(tx_ready_o),
      .tx_word_i(tx_word_i), .tx_word_valid_i(tx_word_valid_i), .tx_word_ready_o(tx_word_ready_o),
      .local_full_i(local_full_i), .inj_data_o(inj_data_o), .ej_data_i(ej_data_i),
      .consume_o(consume_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .rx_overflow_o(rx_overflow_o)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0, cyc = 0, last_cyc = 0;
   bit          b2b = 1'b0, ovf = 1'b0;
   logic [16:0] exp_inj[$];
   logic [15:0] rx_exp[$];
   logic [13:0] preset[$];

   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endfunction

   // Injection monitor: every valid flit must match the next expected flit in order.
   always begin : inj_mon
      logic        fp;
      logic [16:0] e;
      @(posedge clk);
      fp = local_full_i;
      cyc++;
      #1;
      if (!rst) chk("inj_in_reset", 32'(inj_data_o), 32'd0);
      else if (inj_data_o[16]) begin
         chk("flit_vs_full", 32'(fp), 32'd0);
         if (exp_inj.size() == 0) chk("unexpected_flit", 32'(inj_data_o), 32'd0);
         else begin
            e = exp_inj.pop_front();
            chk("flit", 32'(inj_data_o), 32'(e));
            if (e[15]) chk("idle_after_last", 32'(tx_ready_o), 32'd1);
            if (b2b && e[15:14] != 2'b01) chk("b2b_gap", 32'(cyc - last_cyc), 32'd1);
         end
         last_cyc = cyc;
      end else chk("idle_flit_zero", 32'(inj_data_o), 32'd0);
   end

   // Ejection monitor: FIFO model updated with the inputs seen at each edge.
   always begin : ej_mon
      logic        ps, pp;
      logic [15:0] d, dd;
      @(posedge clk);
      ps = ej_data_i[16];
      d  = ej_data_i[15:0];
      pp = rx_exp.size() != 0 && rx_ready_i;
      #1;
      if (!rst) begin
         rx_exp.delete();
         ovf = 1'b0;
      end else begin
         if (pp) dd = rx_exp.pop_front();
         if (ps) begin
            if (rx_exp.size() < RXD) rx_exp.push_back(d);
            else ovf = 1'b1;
         end
         chk("consume", 32'(consume_o), 32'(pp));
         chk("rx_valid", 32'(rx_valid_o), 32'(rx_exp.size() != 0));
         if (rx_exp.size() != 0) chk("rx_data", 32'(rx_data_o), 32'(rx_exp[0]));
         chk("overflow", 32'(rx_overflow_o), 32'(ovf));
      end
   end

   task automatic chk_reset_outs();
      chk("rst_inj", 32'(inj_data_o), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);
      chk("rst_word_ready", 32'(tx_word_ready_o), 32'd0);
      chk("rst_consume", 32'(consume_o), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
      chk("rst_rx_data", 32'(rx_data_o), 32'd0);
      chk("rst_overflow", 32'(rx_overflow_o), 32'd0);
   endtask

   // fmode: 0 never full, 1 random stalls/bubbles, 2 full held 3 cycles after first body word.
   task automatic send_pkt(input logic [5:0] d, input logic [3:0] l, input int fmode, input int abort_at);
      logic [13:0] w[$];
      int idx = 0, g = 0, held = 0;
      bit resumed = 1'b0;
      if (preset.size() != 0) w = preset;
      else for (int i = 0; i < int'(l); i++) w.push_back(14'($urandom));
      preset.delete();
      exp_inj.push_back({1'b1, l == 4'd0 ? 2'b11 : 2'b01, d, NID, 2'b00});
      for (int i = 0; i < int'(l); i++) exp_inj.push_back({1'b1, i == int'(l) - 1 ? 2'b10 : 2'b00, w[i]});
      @(negedge clk);
      tx_valid_i = 1'b1;
      tx_dest_i  = d;
      tx_len_i   = l;
      local_full_i = fmode == 1 ? ($urandom_range(0, 9) < 3) : 1'b0;
      #1;
      while (!tx_ready_o && g < 200) begin
         @(negedge clk);
         local_full_i = fmode == 1 ? ($urandom_range(0, 9) < 3) : 1'b0;
         #1;
         g++;
      end
      chk("accept_timeout", 32'(g < 200), 32'd1);
      @(negedge clk);
      tx_valid_i = 1'b0;
      g = 0;
      while (idx < int'(l) && g < 500 && idx != abort_at) begin
         local_full_i    = fmode == 1 ? ($urandom_range(0, 9) < 3) : (fmode == 2 && idx == 1 && held < 3);
         tx_word_valid_i = fmode == 1 ? ($urandom_range(0, 9) < 7) : 1'b1;
         tx_word_i       = tx_word_valid_i ? w[idx] : 14'($urandom);
         #1;
         if (local_full_i) begin
            chk("word_ready_when_full", 32'(tx_word_ready_o), 32'd0);
            if (fmode == 2) held++;
         end else if (fmode == 2 && held == 3 && !resumed) begin
            chk("resume_after_full", 32'(tx_word_ready_o), 32'd1);
            resumed = 1'b1;
         end
         if (tx_word_ready_o) idx++;
         g++;
         @(negedge clk);
      end
      tx_word_valid_i = 1'b0;
      local_full_i    = 1'b0;
      chk("pkt_timeout", 32'(g < 500), 32'd1);
   endtask

   task automatic drain();
      int g = 0;
      while (exp_inj.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain", 32'(exp_inj.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      tx_valid_i = 1'b0; tx_dest_i = '0; tx_len_i = '0;
      tx_word_i = '0; tx_word_valid_i = 1'b0; local_full_i = 1'b0;
      ej_data_i = '0; rx_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outs();
      rst = 1'b1;

      preset = '{14'h0AA, 14'h0BB};
      b2b = 1'b1;
      send_pkt(6'd12, 4'd2, 0, -1);
      drain();
      b2b = 1'b0;
      @(negedge clk);
      chk("after_pkt_inj", 32'(inj_data_o), 32'd0);
      chk("after_pkt_ready", 32'(tx_ready_o), 32'd1);

      send_pkt(6'd5, 4'd0, 0, -1);
      drain();
      send_pkt(6'd20, 4'd5, 2, -1);
      drain();

      send_pkt(6'd33, 4'd6, 0, 2);
      rst = 1'b0;
      #1;
      chk_reset_outs();
      exp_inj.delete();
      @(negedge clk);
      rst = 1'b1;
      send_pkt(6'd40, 4'd3, 0, -1);
      drain();

      send_pkt(6'd63, 4'd15, 1, -1);
      drain();
      repeat (25) begin
         send_pkt(6'($urandom), 4'($urandom), 1, -1);
         drain();
      end

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ej_data_i = {1'b1, 16'hA000 | 16'(i)};
      end
      @(negedge clk);
      ej_data_i = '0;
      chk("ovf_after_5", 32'(rx_overflow_o), 32'd1);
      rx_ready_i = 1'b1;
      repeat (4) @(negedge clk);
      rx_ready_i = 1'b0;
      @(negedge clk);
      chk("empty_after_4_pops", 32'(rx_valid_o), 32'd0);

      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ej_data_i = {1'b1, 16'h5500 | 16'(i)};
      end
      @(negedge clk);
      ej_data_i  = {1'b1, 16'h55FF};
      rx_ready_i = 1'b1;
      @(negedge clk);
      ej_data_i  = '0;
      rx_ready_i = 1'b0;
      chk("full_pushpop_no_ovf", 32'(rx_overflow_o), 32'd0);
      chk("full_pushpop_head", 32'(rx_data_o), 32'h5501);
      rx_ready_i = 1'b1;
      repeat (5) @(negedge clk);
      rx_ready_i = 1'b0;

      repeat (300) begin
         @(negedge clk);
         ej_data_i  = {1'($urandom_range(0, 1)), 16'($urandom)};
         rx_ready_i = $urandom_range(0, 9) < 4;
      end
      @(negedge clk);
      ej_data_i  = '0;
      rx_ready_i = 1'b1;
      repeat (6) @(negedge clk);
      chk("final_empty", 32'(rx_valid_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
